can_bit_stuffer: RTL and testbench

Transmit-side bit-stuffing stage of the CAN controller; the counterpart of the receive-side destuffer. It takes unstuffed frame bits from the frame generator one at a time and drives the TX line once per bit time. After STUFF_LEN consecutive identical bits in the stuffed region it inserts one complementary stuff bit. It also compares the monitored RX bus level at each sample point against the driven bit and flags mismatches to the frame layer.

---
 rtl/can_bit_stuffer.sv | 70 +++++++
 tb/tb_can_bit_stuffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/can_bit_stuffer.sv
// rtl/can_bit_stuffer.sv - CAN transmit bit stuffer with TX/RX bit monitor
// Inserts one complementary bit after STUFF_LEN identical stuffed-region bits.
module can_bit_stuffer #(
  parameter int STUFF_LEN = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_point,
  input  logic sample_point,
  input  logic bit_in,
  input  logic bit_stuff_en,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic rx,
  output logic tx,
  output logic stuff_active,
  output logic underrun,
  output logic bit_mismatch
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          stuff_due;

  assign stuff_due = (cnt == CW'(STUFF_LEN));
  assign bit_ready = tx_point & ~stuff_due;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx           <= 1'b1;
      stuff_active <= 1'b0;
      underrun     <= 1'b0;
      bit_mismatch <= 1'b0;
      cnt          <= '0;
      last_bit     <= 1'b1;
    end else begin
      underrun     <= 1'b0;
      // tx here is still the value on the bus before any same-cycle update
      bit_mismatch <= sample_point & (rx != tx);
      if (tx_point) begin
        if (stuff_due) begin
          tx           <= ~last_bit;
          last_bit     <= ~last_bit;
          stuff_active <= 1'b1;
          cnt          <= CW'(1);
        end else if (bit_valid) begin
          tx           <= bit_in;
          last_bit     <= bit_in;
          stuff_active <= 1'b0;
          if (!bit_stuff_en)
            cnt <= '0;
          else if (cnt == '0 || bit_in != last_bit)
            cnt <= CW'(1);
          else
            cnt <= cnt + CW'(1);
        end else begin
          // Starved: idle the bus recessive and restart run tracking
          tx           <= 1'b1;
          last_bit     <= 1'b1;
          stuff_active <= 1'b0;
          cnt          <= '0;
          underrun     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// tb/tb_can_bit_stuffer.sv - directed scoreboard bench for can_bit_stuffer
module tb_can_bit_stuffer;

  logic clk = 1'b0;
  logic reset;
  logic tx_point, sample_point, bit_in, bit_stuff_en, bit_valid, rx;
  logic bit_ready, tx, stuff_active, underrun, bit_mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic tx;
    logic st;
    logic und;
    logic mm;
  } exp_t;
  exp_t q[$];

  can_bit_stuffer #(.STUFF_LEN(5)) dut (
    .clk(clk), .reset(reset), .tx_point(tx_point), .sample_point(sample_point),
    .bit_in(bit_in), .bit_stuff_en(bit_stuff_en), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .rx(rx), .tx(tx), .stuff_active(stuff_active),
    .underrun(underrun), .bit_mismatch(bit_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One bit time: tx_point strobe (optionally with sample_point), then one idle clk.
  task automatic step(input logic v, input logic b, input logic se,
                      input logic exp_rdy, input logic exp_tx, input logic exp_st,
                      input logic exp_und, input logic sp = 1'b0,
                      input logic rxv = 1'b1, input logic exp_mm = 1'b0);
    exp_t e;
    @(negedge clk);
    bit_valid = v; bit_in = b; bit_stuff_en = se;
    tx_point = 1'b1; sample_point = sp; rx = rxv;
    #1 chk("bit_ready", bit_ready, exp_rdy);
    q.push_back({exp_tx, exp_st, exp_und, exp_mm});
    @(negedge clk);
    tx_point = 1'b0; sample_point = 1'b0; bit_valid = 1'b0;
    e = q.pop_front();
    chk("tx", tx, e.tx);
    chk("stuff_active", stuff_active, e.st);
    chk("underrun", underrun, e.und);
    chk("bit_mismatch", bit_mismatch, e.mm);
    @(negedge clk);
    chk("underrun_pulse_end", underrun, 1'b0);
    chk("mismatch_pulse_end", bit_mismatch, 1'b0);
    chk("tx_hold", tx, e.tx);
  endtask

  task automatic sample(input logic rxv, input logic exp_mm, input logic exp_tx);
    exp_t e;
    @(negedge clk);
    sample_point = 1'b1; rx = rxv;
    q.push_back({exp_tx, 1'b0, 1'b0, exp_mm});
    @(negedge clk);
    sample_point = 1'b0;
    e = q.pop_front();
    chk("mismatch_sample", bit_mismatch, e.mm);
    chk("tx_no_tx_point", tx, e.tx);
    @(negedge clk);
    chk("mismatch_one_clk", bit_mismatch, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tx_point = 1'b0; sample_point = 1'b0; bit_in = 1'b0;
    bit_stuff_en = 1'b0; bit_valid = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_stuff", stuff_active, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_mismatch", bit_mismatch, 1'b0);
    chk("rst_ready_idle", bit_ready, 1'b0);
    reset = 1'b0;

    // Build a run of three dominant bits, then reset asynchronously mid-run
    repeat (3) step(1, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_stuff", stuff_active, 1'b0);
    chk("async_rst_underrun", underrun, 1'b0);
    chk("async_rst_mismatch", bit_mismatch, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Run restarts from zero: five 0s, stuff 1, then held sixth 0
    repeat (5) step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0, 0, 0);

    // Five 1s stuffed, then non-stuffed 1 waits behind the stuff 0
    repeat (5) step(1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1, 0, 0);

    // Stuff 0 starts a run: four more 0s trigger a second stuff bit
    repeat (5) step(1, 1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    repeat (4) step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0, 0, 0);

    // Last CRC bit completes the run; stuff precedes the delimiter
    repeat (4) step(1, 0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    repeat (6) step(1, 1, 0, 1, 1, 0, 0);

    // Underrun with cnt=2 clears the run; stuff only after the fifth 1
    repeat (2) step(1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 1);
    repeat (5) step(1, 1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0, 0, 0);

    // Bus monitor: tx is 0 here
    sample(1'b1, 1'b1, 1'b0);
    sample(1'b0, 1'b0, 1'b0);
    // Coincident strobes compare the pre-update tx
    step(1, 1, 0, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 1, 0, 0, 0, 1'b1, 1'b0, 1'b1);

    chk("queue_drained", q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
